// File: rtl/scaler_hresample.sv
// Horizontal nearest-neighbour resampler for the axis_scaler pipeline.
// Consumes one s_last-delimited source line and emits dst output pixels;
// output pixel j takes source pixel floor(j*step).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cfg_step, cfg_dst_width    line config, sampled at line start
//   s_valid/s_data/s_user/s_last/s_ready   source pixel stream
//   m_valid/m_data/m_user/m_last/m_ready   registered output pixel stream
module scaler_hresample #(
    parameter int unsigned C_DATA_WIDTH = 12,
    parameter int unsigned C_WIDTH_BITS = 12,
    parameter int unsigned C_FRAC_BITS  = 8,
    parameter int unsigned C_STEP_BITS  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [C_STEP_BITS-1:0]  cfg_step,
    input  logic [C_WIDTH_BITS-1:0] cfg_dst_width,
    input  logic                    s_valid,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    input  logic                    s_user,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    m_valid,
    output logic [C_DATA_WIDTH-1:0] m_data,
    output logic                    m_user,
    output logic                    m_last,
    input  logic                    m_ready
);

    localparam int unsigned ACC_W = C_WIDTH_BITS + C_FRAC_BITS + 1;
    localparam int unsigned INT_W = ACC_W - C_FRAC_BITS;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic                    new_line;
    logic [C_STEP_BITS-1:0]  step_q;
    logic [C_WIDTH_BITS-1:0] dst_q;
    logic [ACC_W-1:0]        acc;
    logic [C_WIDTH_BITS-1:0] sx;
    logic [C_WIDTH_BITS-1:0] ox;
    logic [C_DATA_WIDTH-1:0] hold;

    logic [C_STEP_BITS-1:0]  step_c;
    logic [C_WIDTH_BITS-1:0] dst_c;
    logic [ACC_W-1:0]        acc_nx;
    logic [C_WIDTH_BITS-1:0] ox_after;
    logic                    hit;
    logic                    room;
    logic                    out_last;
    logic                    onext;
    logic                    snext;
    logic                    emit;
    logic                    line_done;

    // Until the first pixel of a line is seen, config comes straight from the cfg ports.
    always_comb begin
        step_c = step_q;
        dst_c  = dst_q;
        if (new_line) begin
            step_c = (cfg_step == '0) ? C_STEP_BITS'(1) : cfg_step;
            dst_c  = cfg_dst_width;
        end
    end

    assign acc_nx   = acc + ACC_W'(step_c);
    assign hit      = (acc[ACC_W-1:C_FRAC_BITS] == INT_W'(sx));
    assign room     = (ox < dst_c);
    assign out_last = (ox == dst_c - C_WIDTH_BITS'(1));
    assign onext    = ~m_valid | m_ready;
    assign snext    = s_valid & s_ready;
    assign emit     = (state == RUN) && s_valid && room && hit && onext;
    assign ox_after = emit ? ox + C_WIDTH_BITS'(1) : ox;

    // Source accept: a hit pixel is held while the next sample still maps to it.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            RUN: begin
                if (!room || !hit) begin
                    s_ready = 1'b1;
                end else begin
                    s_ready = onext &&
                              ((acc_nx[ACC_W-1:C_FRAC_BITS] != INT_W'(sx)) || out_last);
                end
            end
            PAD:     s_ready = 1'b0;
            DRAIN:   s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    // Line ends when both the source line and the output line are finished.
    always_comb begin
        line_done = 1'b0;
        case (state)
            RUN:     line_done = snext && s_last && (ox_after >= dst_c);
            PAD:     line_done = onext && out_last;
            DRAIN:   line_done = snext && s_last;
            default: line_done = 1'b0;
        endcase
    end

    // State, counters and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            new_line <= 1'b1;
            step_q   <= '0;
            dst_q    <= '0;
            acc      <= '0;
            sx       <= '0;
            ox       <= '0;
            hold     <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_user   <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (s_valid && new_line) begin
                        step_q   <= step_c;
                        dst_q    <= dst_c;
                        new_line <= 1'b0;
                    end
                    if (emit) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        m_user  <= s_user && (ox == '0);
                        m_last  <= out_last;
                        acc     <= acc_nx;
                        ox      <= ox_after;
                    end
                    if (snext) begin
                        sx   <= sx + C_WIDTH_BITS'(1);
                        hold <= s_data;
                        if (ox_after >= dst_c) begin
                            if (!s_last) begin
                                state <= DRAIN;
                            end
                        end else if (s_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (onext) begin
                        m_valid <= 1'b1;
                        m_data  <= hold;
                        m_user  <= 1'b0;
                        m_last  <= out_last;
                        ox      <= ox + C_WIDTH_BITS'(1);
                    end
                end
                DRAIN: begin
                end
                default: state <= RUN;
            endcase
            if (line_done) begin
                state    <= RUN;
                new_line <= 1'b1;
                acc      <= '0;
                sx       <= '0;
                ox       <= '0;
            end
        end
    end

endmodule

// File: doc/scaler_hresample.md
Name: scaler_hresample

Overview:
- Horizontal nearest-neighbour resampler for the axis_scaler pipeline.
- Consumes one source line per s_last-delimited packet and emits cfg_dst_width output pixels per line.
- Output pixel j takes source pixel floor(j*step).
- Sits directly upstream of scaler_relay; its registered m_* outputs feed the relay's s_* inputs, and the relay provides the skid/timing break.

Parameters:
- C_DATA_WIDTH, 12, pixel data width.
- C_WIDTH_BITS, 12, width of pixel counters and cfg_dst_width.
- C_FRAC_BITS, 8, fractional bits of cfg_step.
- C_STEP_BITS, 12, total bits of cfg_step (integer part = C_STEP_BITS - C_FRAC_BITS).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cfg_step  input  C_STEP_BITS  source pixels per output pixel, unsigned fixed point; sampled at line start.
- cfg_dst_width  input  C_WIDTH_BITS  output pixels per line; sampled at line start.
- s_valid  input  1  source pixel valid.
- s_data  input  C_DATA_WIDTH  source pixel.
- s_user  input  1  start-of-frame, on first pixel of frame.
- s_last  input  1  last source pixel of line.
- s_ready  output  1  source accept.
- m_valid  output  1  output pixel valid (registered).
- m_data  output  C_DATA_WIDTH  output pixel (registered).
- m_user  output  1  start-of-frame, on first output pixel of the frame's first line.
- m_last  output  1  last output pixel of line.
- m_ready  input  1  downstream accept.

Behaviour:
- Handshakes: snext = s_valid && s_ready; onext = ~m_valid || m_ready (output register may load).
- Reset: m_valid=0, m_data=0, m_user=0, m_last=0; state=RUN; acc=0, sx=0, ox=0; line config reloads on the first cycle after reset.
- Line start: on the first snext of a line, latch step=max(cfg_step,1) and dst=cfg_dst_width; acc=0, sx=0, ox=0.
- Width rule: acc is C_WIDTH_BITS+C_FRAC_BITS+1 bits; its integer part is acc_int.
- hit means acc_int==sx.
- RUN, s_valid high, hit, ox<dst:
  - Requires onext.
  - Load m_data=s_data, m_valid=1, m_user=s_user&&(ox==0), m_last=(ox==dst-1).
  - acc+=step; ox+=1.
  - s_ready=onext && ((acc+step)_int!=sx || ox==dst-1). The pixel is held (not consumed) while more samples still map to it.
- RUN, s_valid high, not hit: s_ready=1; pixel is skipped (downscale).
- Source consumed (snext):
  - sx+=1; data is copied to the hold register.
  - If s_last and ox_after<dst, go to PAD.
  - If s_last and ox_after==dst, the line is complete; next snext starts a new line.
- ox reaches dst without s_last consumed: go to DRAIN.
- PAD:
  - s_ready=0.
  - On each onext, emit the hold register; ox+=1; m_last on ox==dst-1.
  - After the final emit, return to RUN (new line).
- DRAIN:
  - s_ready=1; pixels are discarded, no output.
  - On snext with s_last, return to RUN (new line).
- dst==0: line enters DRAIN from its first pixel; no output.
- m_valid deassertion: m_valid clears when m_ready && no new load.
- Stall rule: m_data/m_user/m_last stay stable while m_valid && !m_ready.
- Latency: 1 cycle from accepted/held source pixel to m_valid.
- Throughput: 1 output pixel per cycle when not back-pressured.
- s_ready is combinational from state, counters, s_valid and m_ready; it never depends on s_data.
- Reset mid-line: all state is discarded. The bench must restart the input on a line boundary.
- Simultaneous last-output and last-source on the same snext: line completes in RUN, with no PAD or DRAIN cycle.

Test Plan:
- Identity: C_FRAC_BITS=8, step=0x100, dst=4, source 10,11,12,13 (last on 13, user on 10) -> outputs 10,11,12,13; m_user on 10; m_last on 13; 4 consecutive cycles with m_ready=1.
- Downscale: step=0x200, dst=2, source 1,2,3,4 -> outputs 1,3; m_last on 3; source pixels 2 and 4 accepted with no output; s_ready stays 1.
- Upscale: step=0x080, dst=4, source 5,6 -> outputs 5,5,6,6; s_ready low on the first emit of each source pixel, high on the second; m_last on the final 6.
- Pad: step=0x100, dst=6, source 1,2,3,4 (last on 4) -> outputs 1,2,3,4,4,4; s_ready=0 during the two PAD cycles; m_last on the final 4.
- Drain + next line: dst=2, step=0x100, source 1..5 then a new line 7,8 -> outputs 1,2 (last on 2), then 7,8; pixels 3,4,5 dropped.
- Backpressure/reset:
  - Identity config with m_ready toggling 1,0,0,1 -> m_data held stable while stalled; no pixel lost or duplicated.
  - Assert reset mid-line -> next cycle m_valid=0, and the following line resamples from acc=0.
